mist_dump_trig: RTL and testbench

MIST_DUMP_TRIG -- requirements
Module: mist_dump_trig

---
 rtl/mist_dump_pkg.sv | 22 ++
 rtl/mist_dump_edge.sv | 29 ++
 rtl/mist_dump_trig.sv | 102 ++++++++++
 tb/tb_mist_dump_trig.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mist_dump_pkg.sv
// Shared types for the MiST frame-dump trigger.
// State encoding and frame-count width live here.
package mist_dump_pkg;

    localparam int FRAME_W = 32;

    typedef logic [FRAME_W-1:0] frame_t;

    localparam frame_t FRAME_MAX = '1;

    typedef enum logic [1:0] {
        ST_WAIT_DL = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DUMP    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic reached(input frame_t cnt, input frame_t lim);
        return cnt >= lim;
    endfunction

endpackage

// File: rtl/mist_dump_edge.sv
// Single-register input capture with rise/fall detect.
// Both flops reset to the idle level so release never fakes an edge.
module mist_dump_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic cur_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            cur_q  <= d_i;
            prev_q <= cur_q;
        end
    end

    assign rise_o = cur_q & ~prev_q;
    assign fall_o = ~cur_q & prev_q;

endmodule

// File: rtl/mist_dump_trig.sv
// Frame-window dump trigger: counts vsync frames and opens a dump
// window between START_FRAME and STOP_FRAME once the ROM is loaded.
import mist_dump_pkg::*;

module mist_dump_trig #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] STOP_FRAME  = 32'd0,
    parameter bit          WAIT_DL     = 1'b1,
    parameter logic [15:0] DL_GUARD    = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_vs,
    input  logic        led,
    output frame_t      frame_cnt,
    output logic        dump_on,
    output logic        dump_start,
    output logic        dump_stop,
    output logic [1:0]  st
);

    localparam state_e ST_INIT = WAIT_DL ? ST_WAIT_DL : ST_ARMED;

    logic        vs_rise, vs_fall;
    logic        led_rise, led_fall;
    logic        led_done;
    logic        dl_abort;
    state_e      st_q, st_d;
    frame_t      frame_cnt_q;
    logic [15:0] guard_q;
    logic        dump_on_q, dump_start_q, dump_stop_q;

    mist_dump_edge #(.RST_VAL(1'b1)) u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (vga_vs),
        .rise_o (vs_rise),
        .fall_o (vs_fall)
    );

    mist_dump_edge #(.RST_VAL(1'b0)) u_led_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (led),
        .rise_o (led_rise),
        .fall_o (led_fall)
    );

    // led bounces right after power-up; ignore falls until the guard expires
    assign led_done = led_fall && (guard_q == DL_GUARD);
    assign dl_abort = WAIT_DL && led_rise &&
                      (st_q == ST_ARMED || st_q == ST_DUMP);

    always_comb begin
        st_d = st_q;
        if (dl_abort) begin
            st_d = ST_WAIT_DL;
        end else begin
            unique case (st_q)
                ST_WAIT_DL: if (led_done) st_d = ST_ARMED;
                ST_ARMED: begin
                    if (vs_fall && reached(frame_cnt_q, START_FRAME))
                        st_d = ST_DUMP;
                end
                ST_DUMP: begin
                    if (vs_fall && STOP_FRAME != 32'd0 &&
                        reached(frame_cnt_q, STOP_FRAME))
                        st_d = ST_DONE;
                end
                ST_DONE: st_d = ST_DONE;
                default: st_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= ST_INIT;
            frame_cnt_q  <= '0;
            guard_q      <= '0;
            dump_on_q    <= 1'b0;
            dump_start_q <= 1'b0;
            dump_stop_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (vs_fall && frame_cnt_q != FRAME_MAX)
                frame_cnt_q <= frame_cnt_q + 32'd1;
            if (guard_q != DL_GUARD)
                guard_q <= guard_q + 16'd1;
            dump_on_q    <= (st_d == ST_DUMP);
            dump_start_q <= (st_d == ST_DUMP) && !dump_on_q;
            dump_stop_q  <= (st_d != ST_DUMP) && dump_on_q;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign dump_on    = dump_on_q;
    assign dump_start = dump_start_q;
    assign dump_stop  = dump_stop_q;
    assign st         = st_q;

endmodule

// File: tb/tb_mist_dump_trig.sv
// Bench for mist_dump_trig: three parameter sets share one stimulus
// stream and are compared every cycle against a frame-level model.
module tb_mist_dump_trig;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vga_vs = 1'b1;
    logic led = 1'b0;

    logic [2:0][31:0] fc;
    logic [2:0]       on, sa, so;
    logic [2:0][1:0]  stv;

    always #5 clk = ~clk;

    mist_dump_trig #(
        .START_FRAME(32'd3), .STOP_FRAME(32'd6),
        .WAIT_DL(1'b1), .DL_GUARD(16'd1000)
    ) dut_a (
        .clk(clk), .rst(rst), .vga_vs(vga_vs), .led(led),
        .frame_cnt(fc[0]), .dump_on(on[0]), .dump_start(sa[0]),
        .dump_stop(so[0]), .st(stv[0])
    );

    mist_dump_trig #(
        .START_FRAME(32'd2), .STOP_FRAME(32'd0),
        .WAIT_DL(1'b1), .DL_GUARD(16'd1000)
    ) dut_b (
        .clk(clk), .rst(rst), .vga_vs(vga_vs), .led(led),
        .frame_cnt(fc[1]), .dump_on(on[1]), .dump_start(sa[1]),
        .dump_stop(so[1]), .st(stv[1])
    );

    mist_dump_trig #(
        .START_FRAME(32'd0), .STOP_FRAME(32'd2),
        .WAIT_DL(1'b0), .DL_GUARD(16'd4)
    ) dut_c (
        .clk(clk), .rst(rst), .vga_vs(vga_vs), .led(led),
        .frame_cnt(fc[2]), .dump_on(on[2]), .dump_start(sa[2]),
        .dump_stop(so[2]), .st(stv[2])
    );

    int unsigned p_start[3] = '{3, 2, 0};
    int unsigned p_stop[3]  = '{6, 0, 2};
    bit          p_wdl[3]   = '{1'b1, 1'b1, 1'b0};
    int          p_grd[3]   = '{1000, 1000, 4};

    int          m_st[3];
    logic [31:0] m_fc[3];
    bit          m_on[3], m_sa[3], m_so[3];
    int          m_g[3];
    bit          s_vs_c, s_vs_p, s_ld_c, s_ld_p;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] a_start_fc, a_stop_fc;
    int          b_stops, b_low;
    bit          b_track = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = p_wdl[i] ? 0 : 1;
            m_fc[i] = 32'd0;
            m_on[i] = 1'b0;
            m_sa[i] = 1'b0;
            m_so[i] = 1'b0;
            m_g[i]  = 0;
        end
        s_vs_c = 1'b1; s_vs_p = 1'b1;
        s_ld_c = 1'b0; s_ld_p = 1'b0;
    endtask

    // Events seen in the two most recent samples take effect at this edge
    task automatic model_edge(input logic v, input logic l);
        bit vf, lr, lf, was;
        logic [31:0] old;
        vf = s_vs_p && !s_vs_c;
        lr = !s_ld_p && s_ld_c;
        lf = s_ld_p && !s_ld_c;
        for (int i = 0; i < 3; i++) begin
            old = m_fc[i];
            was = (m_st[i] == 2);
            if (vf && old != 32'hFFFF_FFFF) m_fc[i] = old + 32'd1;
            if (p_wdl[i] && lr && (m_st[i] == 1 || m_st[i] == 2))
                m_st[i] = 0;
            else if (m_st[i] == 0 && lf && m_g[i] == p_grd[i])
                m_st[i] = 1;
            else if (m_st[i] == 1 && vf && old >= p_start[i])
                m_st[i] = 2;
            else if (m_st[i] == 2 && vf && p_stop[i] != 0 &&
                     old >= p_stop[i])
                m_st[i] = 3;
            if (m_g[i] < p_grd[i]) m_g[i]++;
            m_on[i] = (m_st[i] == 2);
            m_sa[i] = m_on[i] && !was;
            m_so[i] = !m_on[i] && was;
        end
        s_vs_p = s_vs_c; s_vs_c = v;
        s_ld_p = s_ld_c; s_ld_c = l;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%0d.st", i), 32'(stv[i]), 32'(m_st[i]));
            check($sformatf("%0d.fc", i), fc[i], m_fc[i]);
            check($sformatf("%0d.on", i), 32'(on[i]), 32'(m_on[i]));
            check($sformatf("%0d.start", i), 32'(sa[i]), 32'(m_sa[i]));
            check($sformatf("%0d.stop", i), 32'(so[i]), 32'(m_so[i]));
        end
    endtask

    task automatic cyc(input logic v, input logic l);
        vga_vs = v;
        led = l;
        @(posedge clk);
        model_edge(v, l);
        @(negedge clk);
        compare_all();
        if (sa[0]) a_start_fc = fc[0];
        if (so[0]) a_stop_fc = fc[0];
        if (so[1]) b_stops++;
        if (b_track && !on[1]) b_low++;
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        vga_vs = 1'b1;
        led = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d.on", i), 32'(on[i]), 32'd0);
            check($sformatf("rst%0d.start", i), 32'(sa[i]), 32'd0);
            check($sformatf("rst%0d.stop", i), 32'(so[i]), 32'd0);
            check($sformatf("rst%0d.fc", i), fc[i], 32'd0);
            check($sformatf("rst%0d.st", i), 32'(stv[i]),
                  p_wdl[i] ? 32'd0 : 32'd1);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic lv;
        logic vv;

        // Guard window, late re-arm, then a START=3/STOP=6 window
        do_reset();
        a_start_fc = '0;
        a_stop_fc = '0;
        for (int i = 1; i <= 1600; i++) begin
            cyc(1'b1, (i >= 5 && i < 500) || (i >= 700 && i < 1500));
            if (i == 600) check("guard.st", 32'(stv[0]), 32'd0);
        end
        check("armed.stA", 32'(stv[0]), 32'd1);
        check("armed.stB", 32'(stv[1]), 32'd1);
        for (int f = 0; f < 8; f++) begin
            repeat (3) cyc(1'b0, 1'b0);
            repeat (17) cyc(1'b1, 1'b0);
        end
        check("A.start_fc", a_start_fc, 32'd4);
        check("A.stop_fc", a_stop_fc, 32'd7);
        check("A.done", 32'(stv[0]), 32'd3);
        check("A.fc8", fc[0], 32'd8);

        // Download completes after frame 5 with START=2
        do_reset();
        for (int i = 1; i <= 1100; i++) begin
            vv = !(i >= 200 && i < 400 && ((i - 200) % 40) < 3);
            cyc(vv, i >= 3);
        end
        repeat (20) cyc(1'b1, 1'b0);
        check("late.stB", 32'(stv[1]), 32'd1);
        check("late.onB", 32'(on[1]), 32'd0);
        check("late.fcB", fc[1], 32'd5);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0);
        check("late.onB2", 32'(on[1]), 32'd1);
        check("late.fcB2", fc[1], 32'd6);

        // led rise coincident with vsync fall while dumping
        b_stops = 0;
        repeat (2) cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b1, 1'b1);
        check("abort.stops", 32'(b_stops), 32'd1);
        check("abort.stB", 32'(stv[1]), 32'd0);
        check("abort.fcB", fc[1], 32'd7);

        repeat (5) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b0);
        check("rearm.onB", 32'(on[1]), 32'd1);

        // STOP=0 holds the window open; counter saturates
        do_reset();
        for (int i = 1; i <= 1100; i++) cyc(1'b1, i >= 3);
        repeat (5) cyc(1'b1, 1'b0);
        b_low = 0;
        for (int f = 0; f < 100; f++) begin
            if (f == 3) b_track = 1'b1;
            repeat ($urandom_range(1, 4)) cyc(1'b0, 1'b0);
            repeat ($urandom_range(8, 30)) cyc(1'b1, 1'b0);
        end
        b_track = 1'b0;
        check("hold.lowB", 32'(b_low), 32'd0);
        check("hold.fcB", fc[1], 32'd100);
        force dut_b.frame_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut_b.frame_cnt_q;
        m_fc[1] = 32'hFFFF_FFFD;
        for (int f = 0; f < 5; f++) begin
            repeat (3) cyc(1'b0, 1'b0);
            repeat (5) cyc(1'b1, 1'b0);
        end
        check("sat.fcB", fc[1], 32'hFFFF_FFFF);
        check("sat.onB", 32'(on[1]), 32'd1);

        // Random vsync glitches and download toggles
        do_reset();
        lv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) lv = !lv;
            vv = ($urandom_range(0, 15) != 0);
            cyc(vv, lv);
        end

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
